data_sync_launcher: RTL and testbench

//  Source-domain transmitter for the multi-bit bus synchronizer (enable-qualified bus CDC).

---
 rtl/data_sync_pkg.sv | 13 +
 rtl/data_sync_launcher.sv | 96 +++++++++
 tb/tb_data_sync_launcher.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/data_sync_pkg.sv
// data_sync_pkg: state encoding and phase-length helpers shared by the bus-CDC launcher and its receiver bench.
package data_sync_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_e;
  function automatic int hold_cyc(input int dest_stages, input int clk_ratio, input int margin);
    return (dest_stages + 2) * clk_ratio + margin;
  endfunction
  function automatic int low_cyc(input int clk_ratio, input int margin);
    return 2 * clk_ratio + margin;
  endfunction
  function automatic int cnt_width(input int hold, input int low);
    return $clog2((hold > low ? hold : low) + 1);
  endfunction
endpackage

// File: rtl/data_sync_launcher.sv
// data_sync_launcher: source-side transmitter for an enable-qualified multi-bit bus CDC.
module data_sync_launcher
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int DEST_STAGES = 8,
  parameter int CLK_RATIO   = 1,
  parameter int MARGIN      = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 busy
);
  localparam int HOLD_CYC = hold_cyc(DEST_STAGES, CLK_RATIO, MARGIN);
  localparam int LOW_CYC  = low_cyc(CLK_RATIO, MARGIN);
  localparam int CW       = cnt_width(HOLD_CYC, LOW_CYC);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [BUS_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [BUS_WIDTH-1:0]   bus_q, bus_d;
  logic                   en_q, en_d;
  logic                   rdy_q, busy_q;
  logic                   accept, launch, cnt_zero;

  assign cnt_zero = cnt_q == '0;
  assign accept   = data_valid && rdy_q;
  // A pending word leaves straight from the last LOW cycle so back-to-back words keep the 1+HOLD+LOW period.
  assign launch   = pend_vld_q && (state_q == IDLE || (state_q == LOW && cnt_zero));

  always_comb begin
    pend_vld_d  = accept ? 1'b1 : launch ? 1'b0 : pend_vld_q;
    pend_data_d = accept ? data_in : pend_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = launch ? SETUP : IDLE;
      SETUP:   state_d = HIGH;
      HIGH:    state_d = cnt_zero ? LOW : HIGH;
      LOW:     state_d = cnt_zero ? (launch ? SETUP : IDLE) : LOW;
      default: state_d = IDLE;
    endcase
    bus_d = launch ? pend_data_q : bus_q;
    en_d  = state_d == HIGH;
  end

  always_comb begin
    cnt_d = state_q == SETUP              ? CW'(HOLD_CYC - 1) :
            (state_q == HIGH && cnt_zero) ? CW'(LOW_CYC - 1)  :
            !cnt_zero                     ? cnt_q - CW'(1)    : cnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      rdy_q       <= !pend_vld_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      bus_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      busy_q  <= (state_d != IDLE) || pend_vld_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign data_ready = rdy_q;
  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_data_sync_launcher.sv
// tb_data_sync_launcher: directed checks of the launcher at DEST_STAGES=2, CLK_RATIO=1, MARGIN=1 (hold 5, low 3).
module tb_data_sync_launcher;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, bus_enable, busy;
  logic [7:0] unsync_bus;

  int vec = 0, err = 0;
  int to_cnt = 0, stab_err = 0, low_run = 100, mism = 0;
  logic       mon_en = 1'b0, en_prev = 1'b0;
  logic [7:0] bus_prev = '0;
  logic [7:0] sent[$], got[$];

  data_sync_launcher #(.BUS_WIDTH(8), .DEST_STAGES(2), .CLK_RATIO(1), .MARGIN(1)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .unsync_bus(unsync_bus), .bus_enable(bus_enable), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Scoreboard capture on enable rise; the bus may only move after at least 3 low samples.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus_enable && !en_prev) got.push_back(unsync_bus);
      if (unsync_bus !== bus_prev && (bus_enable || low_run < 3)) stab_err++;
      low_run = bus_enable ? 0 : low_run + 1;
    end
    en_prev  = bus_enable;
    bus_prev = unsync_bus;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input bit keep);
    int n = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (!data_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) to_cnt++;
    step();
    sent.push_back(w);
    if (!keep) data_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", n < 200, 1);
  endtask

  initial begin
    #2 RST = 1'b0;
    #1;
    check("rst_en", bus_enable, 0);
    check("rst_bus", unsync_bus, 8'h00);
    check("rst_ready", data_ready, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge CLK);
    #1 check("rst_ready_held", data_ready, 0);
    @(negedge CLK) RST = 1'b1;
    step();
    check("post_rst_ready", data_ready, 1);
    check("post_rst_busy", busy, 0);

    // Single word: accept at E1, bus at E2, enable E3..E7, low E8..E10, idle at E11.
    data_in = 8'hA5;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("w1_ready_e1", data_ready, 0);
    check("w1_busy_e1", busy, 1);
    check("w1_bus_e1", unsync_bus, 8'h00);
    for (int k = 2; k <= 11; k++) begin
      step();
      check($sformatf("w1_en_e%0d", k), bus_enable, (k >= 3 && k <= 7) ? 1 : 0);
      check($sformatf("w1_busy_e%0d", k), busy, (k <= 10) ? 1 : 0);
      check($sformatf("w1_bus_e%0d", k), unsync_bus, 8'hA5);
    end
    check("w1_ready_idle", data_ready, 1);

    // Back-to-back: 8'h22 accepted at E3, launched at E11 (9 cycles after 8'h11).
    data_in = 8'h11;
    data_valid = 1'b1;
    step();
    data_in = 8'h22;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (k == 3) data_valid = 1'b0;
      if (k == 2) check("b2b_ready_e2", data_ready, 1);
      if (k == 3) check("b2b_ready_e3", data_ready, 0);
      check($sformatf("b2b_en_e%0d", k), bus_enable, ((k >= 3 && k <= 7) || (k >= 12 && k <= 16)) ? 1 : 0);
      check($sformatf("b2b_bus_e%0d", k), unsync_bus, (k < 11) ? 8'h11 : 8'h22);
      check($sformatf("b2b_busy_e%0d", k), busy, (k <= 19) ? 1 : 0);
    end

    // Reset in the middle of the HIGH phase.
    send(8'h3C, 0);
    step();
    step();
    check("mid_en_high", bus_enable, 1);
    #3 RST = 1'b0;
    #1;
    check("mid_rst_en", bus_enable, 0);
    check("mid_rst_bus", unsync_bus, 8'h00);
    check("mid_rst_ready", data_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge CLK) RST = 1'b1;
    step();
    check("mid_post_ready", data_ready, 1);
    check("mid_post_busy", busy, 0);
    repeat (12) step();
    check("mid_no_relaunch_en", bus_enable, 0);
    check("mid_no_relaunch_bus", unsync_bus, 8'h00);

    // Backpressure, then random words with gaps, all through the scoreboard.
    sent.delete();
    got.delete();
    low_run = 100;
    mon_en = 1'b1;
    send(8'h01, 1);
    check("bp_ready0", data_ready, 0);
    send(8'h02, 1);
    check("bp_ready1", data_ready, 0);
    check("bp_busy1", busy, 1);
    send(8'h03, 1);
    check("bp_ready2", data_ready, 0);
    send(8'h04, 0);
    drain();
    for (int i = 0; i < 1000; i++) begin
      int gap = $urandom_range(0, 12);
      repeat (gap) step();
      send(8'($urandom), gap == 0);
    end
    drain();
    repeat (2) step();
    mon_en = 1'b0;
    check("sb_count", got.size(), sent.size());
    for (int i = 0; i < got.size() && i < sent.size(); i++)
      if (got[i] !== sent[i]) mism++;
    check("sb_order", mism, 0);
    check("stability", stab_err, 0);
    check("accept_timeouts", to_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
